// File: rtl/alu_control_dm.sv
// alu_control_dm: main opcode/funct decoder, 32-bit ALU with zero flag and a
// word-organised data memory for the 5-stage MIPS pipeline.
// Decoder and ALU are purely combinational; only the memory is clocked.
// Optional build macro: DM_WRITE_FORWARD_EN -- when defined, a read and a write
// to the same word in the same cycle return the write data combinationally.
module alu_control_dm #(
  parameter int NMEM = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  // decoder
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic        regdst,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrc,
  output logic        jump,
  output logic [3:0]  aluctl,
  // ALU
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        zero,
  // data memory
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int IW = $clog2(NMEM);

  logic [31:0]   memQ [NMEM];
  logic [IW-1:0] wordIdx;
  logic          unusedAddrBits;

  // Byte address selects a word; byte offset and high bits simply wrap.
  assign wordIdx        = addr[IW+1:2];
  assign unusedAddrBits = ^{addr[31:IW+2], addr[1:0]};

  // Main decoder: every control line defaults low so unknown encodings act as a NOP.
  always_comb begin
    regdst    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    jump      = 1'b0;
    aluctl    = 4'b0000;
    unique case (opcode)
      6'b000000: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        unique case (funct)
          6'b100000: aluctl = 4'b0010;
          6'b100010: aluctl = 4'b0110;
          6'b100100: aluctl = 4'b0000;
          6'b100101: aluctl = 4'b0001;
          6'b100111: aluctl = 4'b1100;
          6'b100110: aluctl = 4'b1101;
          6'b101010: aluctl = 4'b0111;
          default: begin
            regdst   = 1'b0;
            regwrite = 1'b0;
          end
        endcase
      end
      6'b100011: begin
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = 4'b0010;
      end
      6'b101011: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = 4'b0010;
      end
      6'b000100: begin
        branch_eq = 1'b1;
        aluctl    = 4'b0110;
      end
      6'b000101: begin
        branch_ne = 1'b1;
        aluctl    = 4'b0110;
      end
      6'b001000: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctl   = 4'b0010;
      end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  // ALU: add/sub wrap silently; undefined op codes yield zero.
  always_comb begin
    out = 32'h0;
    unique case (alu_op)
      4'b0000: out = a & b;
      4'b0001: out = a | b;
      4'b0010: out = a + b;
      4'b0110: out = a - b;
      4'b0111: out = {31'h0, $signed(a) < $signed(b)};
      4'b1100: out = ~(a | b);
      4'b1101: out = a ^ b;
      default: out = 32'h0;
    endcase
  end

  assign zero = (out == 32'h0);

  // Memory array: reset clears every word; otherwise write on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMEM; i++) memQ[i] <= 32'h0;
    end else if (wr) begin
      memQ[wordIdx] <= wdata;
    end
  end

  // Combinational read port, forced to zero when disabled or while in reset.
  always_comb begin
    rdata = 32'h0;
    if (rst_n && rd) begin
`ifdef DM_WRITE_FORWARD_EN
      rdata = wr ? wdata : memQ[wordIdx];
`else
      rdata = memQ[wordIdx];
`endif
    end
  end

endmodule

// File: tb/tb_alu_control_dm.sv
// Self-checking bench for alu_control_dm using an expected-value queue.
module tb_alu_control_dm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        regdst, branch_eq, branch_ne, memread, memwrite, memtoreg;
  logic        regwrite, alusrc, jump;
  logic [3:0]  aluctl, alu_op;
  logic [31:0] a, b, out, addr, wdata, rdata;
  logic        zero, rd, wr;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ [$];
  logic [31:0] expV;

  alu_control_dm #(.NMEM(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct(funct),
    .regdst(regdst), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrc(alusrc), .jump(jump), .aluctl(aluctl),
    .alu_op(alu_op), .a(a), .b(b), .out(out), .zero(zero),
    .addr(addr), .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Pushes the expected read value, then pops and compares it against rdata.
  task automatic test_reset();
    // preload a non-zero word so clearing is observable
    @(negedge clk);
    addr = 32'h7C; wdata = 32'hAAAA5555; wr = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr = (i == 0) ? 32'h0 : 32'h7C;
      rd = 1'b1;
      expQ.push_back(32'h0);
      #1;
      expV = expQ.pop_front();
      checks++;
      if (rdata !== expV) begin
        errors++;
        $display("[TB] FAIL reset_read addr=%h got=%h exp=%h", addr, rdata, expV);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0]  opT  [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b0110, 4'b0010, 4'b1111};
    logic [31:0] aT   [6] = '{32'd5, 32'd5, 32'd5, 32'h1234, 32'hFFFFFFFF, 32'h5};
    logic [31:0] bT   [6] = '{32'd7, 32'd7, 32'd7, 32'h1234, 32'h1, 32'h7};
    logic [31:0] outT [6] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      alu_op = opT[i]; a = aT[i]; b = bT[i];
      expQ.push_back(outT[i]);
      expQ.push_back({31'h0, outT[i] == 32'h0});
      #1;
      expV = expQ.pop_front();
      checks++;
      if (out !== expV) begin
        errors++;
        $display("[TB] FAIL alu_out op=%b got=%h exp=%h", alu_op, out, expV);
      end
      expV = expQ.pop_front();
      checks++;
      if ({31'h0, zero} !== expV) begin
        errors++;
        $display("[TB] FAIL alu_zero op=%b got=%b exp=%b", alu_op, zero, expV[0]);
      end
    end
  endtask

  task automatic test_decoder();
    // packed as {regdst,beq,bne,memread,memwrite,memtoreg,regwrite,alusrc,jump,aluctl}
    logic [5:0]  opT  [10] = '{6'b100011, 6'b000000, 6'b000101, 6'b000010, 6'b111111,
                               6'b101011, 6'b000100, 6'b001000, 6'b000000, 6'b000000};
    logic [5:0]  fnT  [10] = '{6'h0, 6'b101010, 6'h0, 6'h0, 6'h0,
                               6'h0, 6'h0, 6'h0, 6'b000000, 6'b100000};
    logic [12:0] expT [10] = '{13'b0_0_0_1_0_1_1_1_0_0010, 13'b1_0_0_0_0_0_1_0_0_0111,
                               13'b0_0_1_0_0_0_0_0_0_0110, 13'b0_0_0_0_0_0_0_0_1_0000,
                               13'b0,                       13'b0_0_0_0_1_0_0_1_0_0010,
                               13'b0_1_0_0_0_0_0_0_0_0110, 13'b0_0_0_0_0_0_1_1_0_0010,
                               13'b0,                       13'b1_0_0_0_0_0_1_0_0_0010};
    logic [12:0] obs;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      opcode = opT[i]; funct = fnT[i];
      expQ.push_back({19'h0, expT[i]});
      #1;
      obs = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
             regwrite, alusrc, jump, aluctl};
      expV = expQ.pop_front();
      checks++;
      if ({19'h0, obs} !== expV) begin
        errors++;
        $display("[TB] FAIL decode op=%b fn=%b got=%b exp=%b", opcode, funct, obs, expV[12:0]);
      end
    end
  endtask

  task automatic test_memory();
    logic [31:0] addrT [3] = '{32'h8, 32'hB, 32'h88};
    @(negedge clk);
    addr = 32'h8; wdata = 32'hDEADBEEF; wr = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = addrT[i]; rd = 1'b1;
      expQ.push_back(32'hDEADBEEF);
      #1;
      expV = expQ.pop_front();
      checks++;
      if (rdata !== expV) begin
        errors++;
        $display("[TB] FAIL mem_read addr=%h got=%h exp=%h", addr, rdata, expV);
      end
    end
    rd = 1'b0;
    expQ.push_back(32'h0);
    #1;
    expV = expQ.pop_front();
    checks++;
    if (rdata !== expV) begin
      errors++;
      $display("[TB] FAIL mem_rd_off got=%h exp=%h", rdata, expV);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    addr = 32'h10; wdata = 32'h11; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    wdata = 32'h22; rd = 1'b1;
`ifdef DM_WRITE_FORWARD_EN
    expQ.push_back(32'h22);
`else
    expQ.push_back(32'h11);
`endif
    #1;
    expV = expQ.pop_front();
    checks++;
    if (rdata !== expV) begin
      errors++;
      $display("[TB] FAIL rw_same_cycle got=%h exp=%h", rdata, expV);
    end
    @(posedge clk); #1;
    wr = 1'b0;
    expQ.push_back(32'h22);
    #1;
    expV = expQ.pop_front();
    checks++;
    if (rdata !== expV) begin
      errors++;
      $display("[TB] FAIL rw_after_edge got=%h exp=%h", rdata, expV);
    end
    rd = 1'b0;
  endtask

  task automatic test_reset_write();
    @(negedge clk);
    addr = 32'h40; wdata = 32'h55; wr = 1'b1; rd = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    expQ.push_back(32'h0);
    expV = expQ.pop_front();
    checks++;
    if (rdata !== expV) begin
      errors++;
      $display("[TB] FAIL rdata_in_reset got=%h exp=%h", rdata, expV);
    end
    @(negedge clk);
    rst_n = 1'b1; addr = 32'h44; wdata = 32'h66; wr = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b1; addr = 32'h40;
    expQ.push_back(32'h0);
    #1;
    expV = expQ.pop_front();
    checks++;
    if (rdata !== expV) begin
      errors++;
      $display("[TB] FAIL reset_blocked_write got=%h exp=%h", rdata, expV);
    end
    addr = 32'h44;
    expQ.push_back(32'h66);
    #1;
    expV = expQ.pop_front();
    checks++;
    if (rdata !== expV) begin
      errors++;
      $display("[TB] FAIL write_after_release got=%h exp=%h", rdata, expV);
    end
    rd = 1'b0;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; alu_op = '0; a = '0; b = '0;
    addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    #12 rst_n = 1'b1;
    test_reset();
    test_alu();
    test_decoder();
    test_memory();
    test_back_to_back();
    test_reset_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_dm.md
# alu_control_dm

Combined execute/memory datapath block for the 5-stage MIPS pipeline: the main opcode/funct decoder, the 32-bit ALU with zero flag, and a word-organised data memory. The decoder drives the ID-stage control bundle, the ALU sits in EX, and the data memory serves lw/sw in MEM. Decoder and ALU are purely combinational; only the memory uses the clock and reset.

## Interface
- NMEM, 32: data-memory depth in 32-bit words; power of two, ≥2.
- clk  input  1  rising-edge clock, used by the memory only.
- rst_n  input  1  reset, asynchronous and active-low; clears memory.
- opcode  input  6  instruction bits [31:26].
- funct  input  6  instruction bits [5:0]; used only when opcode=000000.
- regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump  output  1 each  decoded control.
- aluctl  output  4  decoded ALU operation.
- alu_op  input  4  ALU operation select.
- a, b  input  32  ALU operands.
- out  output  32  ALU result.
- zero  output  1  high when out==0.
- addr  input  32  memory byte address.
- rd, wr  input  1  read enable, write enable.
- wdata  input  32  write data.
- rdata  output  32  read data.

## Operation
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; out=1 or 0), 1100 NOR, 1101 XOR; all other codes give out=0 (so zero=1).
- ADD/SUB wrap modulo 2^32; no overflow detection.
- Decoder; every signal not listed is 0:
  - 000000 R-type: regdst=1, regwrite=1; aluctl from funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 100110→1101, 101010→0111. Any other funct (incl. 000000) decodes to all zeros, so the all-zero word is a NOP.
  - 100011 lw: memread, memtoreg, regwrite, alusrc=1; aluctl=0010.
  - 101011 sw: memwrite, alusrc=1; aluctl=0010.
  - 000100 beq: branch_eq=1, aluctl=0110. 000101 bne: branch_ne=1, aluctl=0110.
  - 001000 addi: regwrite, alusrc=1; aluctl=0010.
  - 000010 j: jump=1.
  - Any other opcode: all outputs 0.
- Memory word index = addr[log2(NMEM)+1:2]; addr[1:0] and upper bits are ignored, so addresses wrap modulo 4·NMEM.
- rd=1: rdata = word at index, combinational. rd=0: rdata=0.
- wr=1: word at index ← wdata on the rising clk edge.
- rd and wr both high, same index, same cycle: rdata shows the pre-edge contents (see Configuration).

## Timing
- Decoder and ALU: zero latency, no state, unaffected by reset.
- Memory read: combinational. A write is visible on rdata immediately after the writing edge.
- rst_n low: all NMEM words cleared to 0 asynchronously; rdata=0 while reset is held; writes ignored.
- Reset released mid-write: writes resume on the first rising edge with rst_n high.
- Reset values: rdata=0; memory all zeros. Decoder and ALU outputs follow their inputs.

## Configuration
- DM_WRITE_FORWARD_EN defined: when rd=1 and wr=1 address the same index, rdata=wdata combinationally in that cycle.
- DM_WRITE_FORWARD_EN undefined: rdata returns the stored (old) word until the edge.

## Test plan
- Reset: pulse rst_n low asynchronously; rd=1 at addr 0x0, 0x7C → rdata=0.
- ALU: a=5, b=7 with ADD→12, SUB→0xFFFFFFFE (zero=0), SLT→1; a=b=0x1234 with SUB → out=0, zero=1; a=0xFFFFFFFF, b=1 with ADD→0, zero=1; alu_op=1111 → out=0.
- Decoder: opcode 100011 → memread, memtoreg, regwrite, alusrc=1, aluctl=0010; 000000/funct 101010 → regdst, regwrite=1, aluctl=0111; 000101 → branch_ne=1, aluctl=0110; 000010 → jump=1; 111111 → all outputs 0.
- Memory: write 0xDEADBEEF to addr 0x8 → later read at 0x8, 0xB (low bits ignored) and 0x88 (wrap, NMEM=32) all give 0xDEADBEEF; rd=0 → rdata=0.
- Simultaneous read/write at 0x10 (old 0x11, new 0x22): rdata=0x22 in the write cycle with DM_WRITE_FORWARD_EN, 0x11 without; 0x22 after the edge in both builds.
- Reset asserted with wr=1 on the clock edge: no write occurs; memory reads 0 after rst_n is released.
